// File: rtl/multicyc_pkg.sv
// Shared constants for the multi-cycle control sequencer.
// The TRAP state exists only when MULTICYC_ILLEGAL_TRAP_EN is defined.
package multicyc_pkg;

   localparam int INSN_LEN       = 32;
   localparam int IMM_TYPE_WIDTH = 3;
   localparam int ALU_OP_WIDTH   = 4;

   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I = 3'd0;
   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S = 3'd1;
   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_B = 3'd2;
   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U = 3'd3;
   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J = 3'd4;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_ALU   = 2'd1;
   localparam logic [1:0] PC_BR    = 2'd2;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 4'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 4'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL    = 4'd2;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT    = 4'd3;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU   = 4'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 4'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL    = 4'd6;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA    = 4'd7;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 4'd8;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 4'd9;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS_B = 4'd10;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
`ifdef MULTICYC_ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } state_e;

   typedef enum logic [2:0] {
      CL_NOP,
      CL_ALU,
      CL_JUMP,
      CL_BRANCH,
      CL_LOAD,
      CL_STORE
   } cls_e;

   function automatic logic [ALU_OP_WIDTH-1:0] alu_fn(
      input logic [2:0] f3,
      input logic       alt
   );
      logic [ALU_OP_WIDTH-1:0] r;
      case (f3)
         3'b000:  r = alt ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = alt ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/multicyc_decode.sv
// Combinational opcode/funct decode: class, immediate format,
// operand selects, ALU operation and illegal-encoding flag.
module multicyc_decode
   import multicyc_pkg::*;
(
   input  logic [INSN_LEN-1:0]       inst,
   output cls_e                      cls,
   output logic [IMM_TYPE_WIDTH-1:0] imm_type,
   output logic                      alu_a_sel,
   output logic                      alu_b_sel,
   output logic [ALU_OP_WIDTH-1:0]   alu_op,
   output logic                      illegal
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       op_ok;
   logic       unused_fields;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];
   assign unused_fields = ^{inst[24:15], inst[11:7]};

   // Only SUB and SRA may set the alternate funct7 bit.
   assign op_ok = (f7 == 7'h00) ||
                  (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));

   always_comb begin
      cls       = CL_NOP;
      imm_type  = IMM_I;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = ALU_ADD;
      illegal   = 1'b0;
      case (opc)
         OPC_LUI: begin
            cls       = CL_ALU;
            imm_type  = IMM_U;
            alu_b_sel = 1'b1;
            alu_op    = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            cls       = CL_ALU;
            imm_type  = IMM_U;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
         end
         OPC_JAL: begin
            cls       = CL_JUMP;
            imm_type  = IMM_J;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
         end
         OPC_JALR: begin
            cls       = CL_JUMP;
            alu_b_sel = 1'b1;
         end
         OPC_BRANCH: cls = CL_BRANCH;
         OPC_LOAD: begin
            cls       = CL_LOAD;
            alu_b_sel = 1'b1;
         end
         OPC_STORE: begin
            cls       = CL_STORE;
            imm_type  = IMM_S;
            alu_b_sel = 1'b1;
         end
         OPC_OP_IMM: begin
            cls       = CL_ALU;
            alu_b_sel = 1'b1;
            alu_op    = alu_fn(f3, f3 == 3'b101 && inst[30]);
         end
         OPC_OP: begin
            if (op_ok) begin
               cls    = CL_ALU;
               alu_op = alu_fn(f3, inst[30]);
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_MISC_MEM, OPC_SYSTEM: cls = CL_NOP;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicyc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer.
// Define MULTICYC_ILLEGAL_TRAP_EN to add the sticky TRAP state and trap port.
module multicyc_ctrl
   import multicyc_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [INSN_LEN-1:0]       inst,
   output logic                      imem_req,
   input  logic                      imem_ack,
   output logic                      ir_we,
   output logic [IMM_TYPE_WIDTH-1:0] imm_type,
   output logic                      alu_a_sel,
   output logic                      alu_b_sel,
   output logic [ALU_OP_WIDTH-1:0]   alu_op,
   input  logic                      br_taken,
   output logic                      dmem_req,
   output logic                      dmem_we,
   input  logic                      dmem_ack,
   output logic                      rf_we,
   output logic [1:0]                wb_sel,
   output logic                      pc_we,
   output logic [1:0]                pc_sel,
   output logic                      retire
`ifdef MULTICYC_ILLEGAL_TRAP_EN
   ,
   output logic                      trap
`endif
);

   state_e                    state_q, state_d;
   cls_e                      cls;
   logic [IMM_TYPE_WIDTH-1:0] dec_imm;
   logic                      dec_a, dec_b;
   logic [ALU_OP_WIDTH-1:0]   dec_op;
   logic                      illegal;
   logic                      rd_nz;
   logic                      drive_sel;

   multicyc_decode u_decode (
      .inst      (inst),
      .cls       (cls),
      .imm_type  (dec_imm),
      .alu_a_sel (dec_a),
      .alu_b_sel (dec_b),
      .alu_op    (dec_op),
      .illegal   (illegal)
   );

`ifndef MULTICYC_ILLEGAL_TRAP_EN
   logic unused_illegal;
   assign unused_illegal = illegal;
`endif

   assign rd_nz = |inst[11:7];

   always_comb begin
      state_d   = state_q;
      drive_sel = 1'b0;
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      retire    = 1'b0;
      imm_type  = '0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = '0;
`ifdef MULTICYC_ILLEGAL_TRAP_EN
      trap      = 1'b0;
`endif
      // Every output is forced low for the whole reset window.
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               drive_sel = 1'b1;
               state_d   = S_EXEC;
`ifdef MULTICYC_ILLEGAL_TRAP_EN
               if (illegal) begin
                  drive_sel = 1'b0;
                  state_d   = S_TRAP;
               end
`endif
            end
            S_EXEC: begin
               drive_sel = 1'b1;
               state_d   = S_FETCH;
               case (cls)
                  CL_ALU: begin
                     rf_we  = rd_nz;
                     pc_we  = 1'b1;
                     retire = 1'b1;
                  end
                  CL_JUMP: begin
                     rf_we  = rd_nz;
                     wb_sel = WB_PC4;
                     pc_we  = 1'b1;
                     pc_sel = PC_ALU;
                     retire = 1'b1;
                  end
                  CL_BRANCH: begin
                     pc_we  = 1'b1;
                     pc_sel = br_taken ? PC_BR : PC_PLUS4;
                     retire = 1'b1;
                  end
                  CL_LOAD, CL_STORE: state_d = S_MEM;
                  default: begin
                     pc_we  = 1'b1;
                     retire = 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               drive_sel = 1'b1;
               dmem_req  = 1'b1;
               dmem_we   = (cls == CL_STORE);
               if (dmem_ack) begin
                  if (cls == CL_STORE) begin
                     pc_we   = 1'b1;
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end
            end
            S_WB: begin
               drive_sel = 1'b1;
               rf_we     = rd_nz;
               wb_sel    = WB_LOAD;
               pc_we     = 1'b1;
               retire    = 1'b1;
               state_d   = S_FETCH;
            end
`ifdef MULTICYC_ILLEGAL_TRAP_EN
            S_TRAP: trap = 1'b1;
`endif
            default: state_d = S_FETCH;
         endcase
      end
      if (drive_sel) begin
         imm_type  = dec_imm;
         alu_a_sel = dec_a;
         alu_b_sel = dec_b;
         alu_op    = dec_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

endmodule

// File: tb/tb_multicyc_ctrl.sv
// Directed bench for multicyc_ctrl; each task walks one scenario
// cycle by cycle and compares outputs on the falling edge.
module tb_multicyc_ctrl;
   import multicyc_pkg::*;

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic [INSN_LEN-1:0]       inst = '0;
   logic                      imem_req, imem_ack = 1'b0, ir_we;
   logic [IMM_TYPE_WIDTH-1:0] imm_type;
   logic                      alu_a_sel, alu_b_sel;
   logic [ALU_OP_WIDTH-1:0]   alu_op;
   logic                      br_taken = 1'b0;
   logic                      dmem_req, dmem_we, dmem_ack = 1'b0;
   logic                      rf_we, pc_we, retire;
   logic [1:0]                wb_sel, pc_sel;
`ifdef MULTICYC_ILLEGAL_TRAP_EN
   logic                      trap;
`endif

   int checks = 0;
   int errors = 0;

   // {imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel, retire}
   logic [10:0] ctl;
   assign ctl = {imem_req, ir_we, dmem_req, dmem_we, rf_we,
                 wb_sel, pc_we, pc_sel, retire};

   always #5 clk = ~clk;

   multicyc_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .inst      (inst),
      .imem_req  (imem_req),
      .imem_ack  (imem_ack),
      .ir_we     (ir_we),
      .imm_type  (imm_type),
      .alu_a_sel (alu_a_sel),
      .alu_b_sel (alu_b_sel),
      .alu_op    (alu_op),
      .br_taken  (br_taken),
      .dmem_req  (dmem_req),
      .dmem_we   (dmem_we),
      .dmem_ack  (dmem_ack),
      .rf_we     (rf_we),
      .wb_sel    (wb_sel),
      .pc_we     (pc_we),
      .pc_sel    (pc_sel),
      .retire    (retire)
`ifdef MULTICYC_ILLEGAL_TRAP_EN
      ,
      .trap      (trap)
`endif
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      br_taken = 1'b1;
      inst = 32'h00500093;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({ctl, imm_type, alu_a_sel, alu_b_sel, alu_op} !== 20'd0) begin
            errors++;
            $display("FAIL reset_c%0d outs got %b %b want all zero",
                     c, ctl, {imm_type, alu_a_sel, alu_b_sel, alu_op});
         end
         next_cycle();
      end
      reset = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      br_taken = 1'b0;
      @(negedge clk);
      checks++;
      if (ctl !== 11'b1_0_0_0_0_00_0_00_0) begin
         errors++;
         $display("FAIL reset_first_fetch ctl got %b want %b",
                  ctl, 11'b1_0_0_0_0_00_0_00_0);
      end
      next_cycle();
   endtask

   task automatic test_addi();
      logic [10:0] exp [4] = '{11'b1_1_0_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b0_0_0_0_1_00_1_00_1,
                               11'b1_0_0_0_0_00_0_00_0};
      inst = 32'h00500093;
      for (int c = 0; c < 4; c++) begin
         imem_ack = (c == 0);
         @(negedge clk);
         checks++;
         if (ctl !== exp[c]) begin
            errors++;
            $display("FAIL addi_c%0d ctl got %b want %b", c + 1, ctl, exp[c]);
         end
         if (c == 2) begin
            checks++;
            if ({imm_type, alu_b_sel, alu_op} !== {IMM_I, 1'b1, ALU_ADD}) begin
               errors++;
               $display("FAIL addi_sel got %b want %b",
                        {imm_type, alu_b_sel, alu_op}, {IMM_I, 1'b1, ALU_ADD});
            end
         end
         next_cycle();
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_load();
      logic [10:0] exp [8] = '{11'b1_1_0_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b0_0_1_0_0_00_0_00_0,
                               11'b0_0_1_0_0_00_0_00_0,
                               11'b0_0_1_0_0_00_0_00_0,
                               11'b0_0_0_0_1_01_1_00_1,
                               11'b1_0_0_0_0_00_0_00_0};
      inst = 32'h0040A103;
      for (int c = 0; c < 8; c++) begin
         imem_ack = (c == 0);
         dmem_ack = (c == 1) || (c == 5);
         @(negedge clk);
         checks++;
         if (ctl !== exp[c]) begin
            errors++;
            $display("FAIL load_c%0d ctl got %b want %b", c + 1, ctl, exp[c]);
         end
         if (c == 2 || c == 4) begin
            checks++;
            if ({imm_type, alu_a_sel, alu_b_sel, alu_op} !==
                {IMM_I, 1'b0, 1'b1, ALU_ADD}) begin
               errors++;
               $display("FAIL load_sel_c%0d got %b want %b", c + 1,
                        {imm_type, alu_a_sel, alu_b_sel, alu_op},
                        {IMM_I, 1'b0, 1'b1, ALU_ADD});
            end
         end
         next_cycle();
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask

   task automatic test_store();
      logic [10:0] exp [6] = '{11'b1_0_0_0_0_00_0_00_0,
                               11'b1_1_0_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b0_0_1_1_0_00_1_00_1,
                               11'b1_0_0_0_0_00_0_00_0};
      inst = 32'h0020A423;
      for (int c = 0; c < 6; c++) begin
         imem_ack = (c == 1);
         dmem_ack = (c == 4);
         @(negedge clk);
         checks++;
         if (ctl !== exp[c]) begin
            errors++;
            $display("FAIL store_c%0d ctl got %b want %b", c + 1, ctl, exp[c]);
         end
         if (c == 3) begin
            checks++;
            if ({imm_type, alu_b_sel} !== {IMM_S, 1'b1}) begin
               errors++;
               $display("FAIL store_sel got %b want %b",
                        {imm_type, alu_b_sel}, {IMM_S, 1'b1});
            end
         end
         next_cycle();
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask

   task automatic test_branch();
      logic [10:0] exp;
      inst = 32'h00208463;
      for (int t = 0; t < 2; t++) begin
         br_taken = (t == 0);
         for (int c = 0; c < 4; c++) begin
            imem_ack = (c == 0);
            case (c)
               0: exp = 11'b1_1_0_0_0_00_0_00_0;
               1: exp = 11'b0_0_0_0_0_00_0_00_0;
               2: exp = (t == 0) ? 11'b0_0_0_0_0_00_1_10_1
                                 : 11'b0_0_0_0_0_00_1_00_1;
               default: exp = 11'b1_0_0_0_0_00_0_00_0;
            endcase
            @(negedge clk);
            checks++;
            if (ctl !== exp) begin
               errors++;
               $display("FAIL branch_t%0d_c%0d ctl got %b want %b",
                        t, c + 1, ctl, exp);
            end
            next_cycle();
         end
      end
      imem_ack = 1'b0;
      br_taken = 1'b0;
   endtask

   task automatic test_jal();
      logic [31:0] ins [2] = '{32'h0000006F, 32'h008000EF};
      logic [10:0] ex3 [2] = '{11'b0_0_0_0_0_10_1_01_1,
                               11'b0_0_0_0_1_10_1_01_1};
      for (int t = 0; t < 2; t++) begin
         inst = ins[t];
         for (int c = 0; c < 3; c++) begin
            imem_ack = (c == 0);
            @(negedge clk);
            if (c == 2) begin
               checks++;
               if (ctl !== ex3[t]) begin
                  errors++;
                  $display("FAIL jal_%0d ctl got %b want %b", t, ctl, ex3[t]);
               end
               checks++;
               if ({imm_type, alu_a_sel, alu_b_sel} !== {IMM_J, 1'b1, 1'b1}) begin
                  errors++;
                  $display("FAIL jal_%0d_sel got %b want %b", t,
                           {imm_type, alu_a_sel, alu_b_sel}, {IMM_J, 1'b1, 1'b1});
               end
            end
            next_cycle();
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_alu_ops();
      logic [31:0] ins [7] = '{32'h402081B3, 32'h40000093, 32'h4030D293,
                               32'h00001297, 32'h0020D333, 32'h0020F3B3,
                               32'h12345237};
      logic [3:0]  ops [7] = '{ALU_SUB, ALU_ADD, ALU_SRA, ALU_ADD,
                               ALU_SRL, ALU_AND, ALU_PASS_B};
      logic        bs  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        as  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic        am  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int t = 0; t < 7; t++) begin
         inst = ins[t];
         for (int c = 0; c < 3; c++) begin
            imem_ack = (c == 0);
            @(negedge clk);
            if (c == 2) begin
               checks++;
               if ({ctl, alu_b_sel, alu_op} !==
                   {11'b0_0_0_0_1_00_1_00_1, bs[t], ops[t]} ||
                   (am[t] && alu_a_sel !== as[t])) begin
                  errors++;
                  $display("FAIL alu_%h got %b %b %b %h want %b %b %b %h",
                           ins[t], ctl, alu_a_sel, alu_b_sel, alu_op,
                           11'b0_0_0_0_1_00_1_00_1, as[t], bs[t], ops[t]);
               end
            end
            next_cycle();
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_nop();
      logic [31:0] ins [2] = '{32'h0FF0000F, 32'h00000073};
      for (int t = 0; t < 2; t++) begin
         inst = ins[t];
         for (int c = 0; c < 3; c++) begin
            imem_ack = (c == 0);
            @(negedge clk);
            if (c == 2) begin
               checks++;
               if (ctl !== 11'b0_0_0_0_0_00_1_00_1) begin
                  errors++;
                  $display("FAIL nop_%h ctl got %b want %b", ins[t], ctl,
                           11'b0_0_0_0_0_00_1_00_1);
               end
            end
            next_cycle();
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_illegal();
      logic [31:0] ins [2] = '{32'h022081B3, 32'h0000007F};
`ifdef MULTICYC_ILLEGAL_TRAP_EN
      for (int t = 0; t < 2; t++) begin
         inst = ins[t];
         for (int c = 0; c < 6; c++) begin
            imem_ack = (c == 0) || (c == 3);
            dmem_ack = (c == 4);
            @(negedge clk);
            if (c >= 2) begin
               checks++;
               if ({ctl, trap} !== {11'd0, 1'b1}) begin
                  errors++;
                  $display("FAIL trap_%h_c%0d got %b %b want %b 1", ins[t],
                           c + 1, ctl, trap, 11'd0);
               end
            end
            next_cycle();
         end
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         reset = 1'b1;
         next_cycle();
         reset = 1'b0;
         @(negedge clk);
         checks++;
         if ({ctl, trap} !== {11'b1_0_0_0_0_00_0_00_0, 1'b0}) begin
            errors++;
            $display("FAIL trap_exit got %b %b want %b 0", ctl, trap,
                     11'b1_0_0_0_0_00_0_00_0);
         end
         next_cycle();
      end
`else
      for (int t = 0; t < 2; t++) begin
         inst = ins[t];
         for (int c = 0; c < 4; c++) begin
            imem_ack = (c == 0);
            @(negedge clk);
            if (c >= 2) begin
               checks++;
               if (ctl !== ((c == 2) ? 11'b0_0_0_0_0_00_1_00_1
                                     : 11'b1_0_0_0_0_00_0_00_0)) begin
                  errors++;
                  $display("FAIL illegal_%h_c%0d ctl got %b", ins[t], c + 1, ctl);
               end
            end
            next_cycle();
         end
      end
`endif
      imem_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [10:0] exp [7] = '{11'b1_1_0_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b0_0_1_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b0_0_0_0_0_00_0_00_0,
                               11'b1_0_0_0_0_00_0_00_0};
      inst = 32'h0040A103;
      for (int c = 0; c < 7; c++) begin
         imem_ack = (c == 0) || (c == 5);
         dmem_ack = (c == 5);
         reset = (c == 4) || (c == 5);
         @(negedge clk);
         checks++;
         if (ctl !== exp[c]) begin
            errors++;
            $display("FAIL rstmid_c%0d ctl got %b want %b", c + 1, ctl, exp[c]);
         end
         next_cycle();
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load();
      test_store();
      test_branch();
      test_jal();
      test_alu_ops();
      test_nop();
      test_illegal();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
